// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared constants and types for the camera burst packer
//
// Purpose: word/pixel geometry, burst length, packer FSM state type and a
// saturating counter helper shared by the packer and its bench.
// Ports: none (package).
package cam_pkg;

  localparam int BURST_BEATS = 16;
  localparam int WORD_W      = 64;
  localparam int PIX_W       = 16;
  localparam int LANES       = WORD_W / PIX_W;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    CAPTURE  = 2'd1,
    PAD      = 2'd2
  } packer_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock first-word-fall-through FIFO
//
// Purpose: generic FWFT FIFO; the head word is always visible on rd_data
// while the FIFO is non-empty (rd_data reads as zero when empty).
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   wr_en, wr_data    push request and data; accepted when not full, or
//                     when full but a pop happens in the same cycle
//   rd_en             pop strobe, ignored while empty
//   rd_data           head word
//   level, full, empty  occupancy status
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             push, pop;

  assign full    = (level_q == (AW+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign pop     = rd_en && !empty;
  assign push    = wr_en && (!full || pop);
  assign level   = level_q;
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d  = level_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: nothing is visible until level says so.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/cam_burst_packer.sv
// rtl/cam_burst_packer.sv - packs 16-bit pixels into burst-aligned 64-bit words
//
// Purpose: gathers four pixels per word, zero-pads each frame to a whole
// 16-word burst and buffers the words for the DRAM writer.
// Ports:
//   fclk, rst                 clock, asynchronous active-high reset
//   enable                    capture enable, sampled at start of frame
//   pix_data/valid/sof/eof    camera pixel stream (cannot stall)
//   dout, dout_valid, dout_ready  FWFT word stream to the writer
//   burst_valid               at least one full burst buffered
//   frame_done                pulse when a frame's last word is stored
//   overflow, drop_count      drop status, cleared by clear_status
module cam_burst_packer
  import cam_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic              fclk,
  input  logic              rst,
  input  logic              enable,
  input  logic [PIX_W-1:0]  pix_data,
  input  logic              pix_valid,
  input  logic              pix_sof,
  input  logic              pix_eof,
  output logic [WORD_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              burst_valid,
  output logic              frame_done,
  output logic              overflow,
  output logic [15:0]       drop_count,
  input  logic              clear_status
);

  localparam int LW = $clog2(DEPTH) + 1;

  packer_state_t            state_q, state_d;
  logic [1:0]               lane_cnt_q, lane_cnt_d;
  logic [3:0]               beat_cnt_q, beat_cnt_d;
  logic [PIX_W*(LANES-1)-1:0] lanes_q, lanes_d;
  logic                     frame_done_q, frame_done_d;
  logic                     overflow_q, overflow_d;
  logic [15:0]              drop_count_q, drop_count_d;
  logic                     burst_valid_q, burst_valid_d;

  logic [1:0]        lane_sel;
  logic              capture_pix, cap_push, pad_active, push_en, push_ok, pop;
  logic              cap_drop, pad_drop;
  logic [3:0]        beat_next;
  logic [WORD_W-1:0] cap_word, push_data;
  logic [LW-1:0]     fifo_level;
  logic              fifo_full, fifo_empty;

  // Word being formed: lanes below the current one come from the holding
  // register, the current lane is the live pixel, lanes above are zero
  // (which is exactly the eof padding of a partial word).
  always_comb begin
    lane_sel    = (state_q == WAIT_SOF) ? 2'd0 : lane_cnt_q;
    capture_pix = pix_valid && (state_q == CAPTURE ||
                                (state_q == WAIT_SOF && pix_sof && enable));
    cap_word = '0;
    for (int i = 0; i < LANES-1; i++) begin
      cap_word[i*PIX_W +: PIX_W] = (2'(i) < lane_sel) ? lanes_q[i*PIX_W +: PIX_W] :
                                   (2'(i) == lane_sel) ? pix_data : '0;
    end
    cap_word[WORD_W-1 -: PIX_W] = (lane_sel == 2'd3) ? pix_data : '0;

    cap_push   = capture_pix && (lane_sel == 2'd3 || pix_eof);
    pad_active = (state_q == PAD);
    push_en    = cap_push || pad_active;
    push_data  = pad_active ? '0 : cap_word;
    pop        = dout_ready && !fifo_empty;
    push_ok    = push_en && (!fifo_full || pop);
    cap_drop   = cap_push && !push_ok;
    // Pixels arriving during padding are lost in groups of four.
    pad_drop   = pad_active && pix_valid && (lane_cnt_q == 2'd3);
    // Only accepted words advance the beat, keeping bursts aligned.
    beat_next  = beat_cnt_q + {3'b0, push_ok};
  end

  always_comb begin
    state_d      = state_q;
    lane_cnt_d   = lane_cnt_q;
    lanes_d      = lanes_q;
    beat_cnt_d   = beat_next;
    frame_done_d = 1'b0;
    if (capture_pix) begin
      lanes_d = cap_word[PIX_W*(LANES-1)-1:0];
      if (pix_eof) begin
        lane_cnt_d = 2'd0;
        if (beat_next == 4'd0) begin
          state_d      = WAIT_SOF;
          frame_done_d = 1'b1;
        end else begin
          state_d = PAD;
        end
      end else begin
        lane_cnt_d = lane_sel + 2'd1;
        state_d    = CAPTURE;
      end
    end else if (pad_active) begin
      if (pix_valid) lane_cnt_d = lane_cnt_q + 2'd1;
      if (push_ok && beat_next == 4'd0) begin
        state_d      = WAIT_SOF;
        frame_done_d = 1'b1;
        lane_cnt_d   = 2'd0;
      end
    end

    // A drop in the same cycle as a clear survives the clear.
    overflow_d = (overflow_q && !clear_status) || cap_drop;
    if (clear_status)                 drop_count_d = {15'b0, cap_drop || pad_drop};
    else if (cap_drop || pad_drop)    drop_count_d = sat_inc16(drop_count_q);
    else                              drop_count_d = drop_count_q;

    burst_valid_d = (fifo_level >= LW'(BURST_BEATS));
  end

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      state_q       <= WAIT_SOF;
      lane_cnt_q    <= '0;
      beat_cnt_q    <= '0;
      lanes_q       <= '0;
      frame_done_q  <= 1'b0;
      overflow_q    <= 1'b0;
      drop_count_q  <= '0;
      burst_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      lane_cnt_q    <= lane_cnt_d;
      beat_cnt_q    <= beat_cnt_d;
      lanes_q       <= lanes_d;
      frame_done_q  <= frame_done_d;
      overflow_q    <= overflow_d;
      drop_count_q  <= drop_count_d;
      burst_valid_q <= burst_valid_d;
    end
  end

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (fclk),
    .rst     (rst),
    .wr_en   (push_en),
    .wr_data (push_data),
    .rd_en   (dout_ready),
    .rd_data (dout),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign dout_valid  = !fifo_empty;
  assign burst_valid = burst_valid_q;
  assign frame_done  = frame_done_q;
  assign overflow    = overflow_q;
  assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_cam_burst_packer.sv
// tb/tb_cam_burst_packer.sv - self-checking bench for cam_burst_packer
module tb_cam_burst_packer;

  logic        fclk = 1'b0, rst = 1'b0, enable = 1'b0;
  logic        pix_valid = 1'b0, pix_sof = 1'b0, pix_eof = 1'b0;
  logic [15:0] pix_data = '0;
  logic        dout_ready = 1'b0, clear_status = 1'b0;
  logic [63:0] dout;
  logic        dout_valid, burst_valid, frame_done, overflow;
  logic [15:0] drop_count;

  int n_tests = 0, n_fail = 0, done_cnt = 0;
  bit mon_en = 1'b0, rnd_ready = 1'b0;
  logic [63:0] exp_q[$];

  typedef struct {
    int n; bit en; bit en_late; int exp_words; int exp_done; bit exp_burst;
  } vec_t;
  vec_t vecs[6];

  cam_burst_packer #(.DEPTH(64)) dut (
    .fclk(fclk), .rst(rst), .enable(enable), .pix_data(pix_data),
    .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_eof(pix_eof),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .burst_valid(burst_valid), .frame_done(frame_done), .overflow(overflow),
    .drop_count(drop_count), .clear_status(clear_status)
  );

  always #5 fclk = ~fclk;

  always @(negedge fclk) if (frame_done) done_cnt++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Random-phase scoreboard: every pop must match the next modelled word.
  always @(negedge fclk) begin : monitor
    logic [63:0] e;
    if (mon_en && dout_valid && dout_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL rnd_word: got %h, want no word", dout);
      end else begin
        e = exp_q.pop_front();
        check("rnd_word", dout, e);
      end
    end
  end

  task automatic tick();
    @(posedge fclk); #1;
    if (rnd_ready) dout_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic pix(input logic [15:0] d, input logic sof, input logic eof);
    pix_valid = 1'b1; pix_data = d; pix_sof = sof; pix_eof = eof;
    tick();
    pix_valid = 1'b0; pix_sof = 1'b0; pix_eof = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; idle(2); rst = 1'b0; idle(1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " dout"}, dout, 64'h0);
    check({tag, " dout_valid"}, dout_valid, 1'b0);
    check({tag, " burst_valid"}, burst_valid, 1'b0);
    check({tag, " frame_done"}, frame_done, 1'b0);
    check({tag, " overflow"}, overflow, 1'b0);
    check({tag, " drop_count"}, drop_count, 16'h0);
  endtask

  // Reference: pixels packed four to a word, lane 0 lowest, frame padded
  // with zero words up to a whole number of 16-word bursts.
  function automatic void model_frame(input logic [15:0] px[$]);
    int nw, tot;
    logic [63:0] w;
    nw  = (px.size() + 3) / 4;
    tot = ((nw + 15) / 16) * 16;
    for (int k = 0; k < tot; k++) begin
      w = '0;
      for (int j = 0; j < 4; j++)
        if (4*k + j < px.size()) w[16*j +: 16] = px[4*k + j];
      exp_q.push_back(w);
    end
  endfunction

  task automatic drain(input string name, output int cnt);
    logic [63:0] e;
    cnt = 0;
    dout_ready = 1'b1;
    for (int c = 0; c < 200 && dout_valid; c++) begin
      if (exp_q.size() != 0) e = exp_q.pop_front();
      else e = 64'hDEAD_DEAD_DEAD_DEAD;
      check(name, dout, e);
      cnt++;
      tick();
    end
    dout_ready = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    logic [15:0] px[$];
    logic [15:0] d;
    int d0, cnt, exp_frames;
    bit en;
    int len;

    vecs[0] = '{n: 64, en: 1, en_late: 0, exp_words: 16, exp_done: 1, exp_burst: 1};
    vecs[1] = '{n: 10, en: 1, en_late: 0, exp_words: 16, exp_done: 1, exp_burst: 1};
    vecs[2] = '{n: 40, en: 0, en_late: 1, exp_words: 0,  exp_done: 0, exp_burst: 0};
    vecs[3] = '{n: 65, en: 1, en_late: 0, exp_words: 32, exp_done: 1, exp_burst: 1};
    vecs[4] = '{n: 1,  en: 1, en_late: 0, exp_words: 16, exp_done: 1, exp_burst: 1};
    vecs[5] = '{n: 63, en: 1, en_late: 0, exp_words: 16, exp_done: 1, exp_burst: 1};

    #1 rst = 1'b1;
    idle(2);
    check_reset_outputs("reset");
    rst = 1'b0;
    idle(1);

    // Table-driven frames: buffered with the writer stalled, then drained.
    for (int v = 0; v < 6; v++) begin
      px = {};
      exp_q = {};
      d0 = done_cnt;
      enable = vecs[v].en;
      for (int i = 0; i < vecs[v].n; i++) begin
        d = 16'(v*256 + i + 1);
        if (vecs[v].en_late && i == vecs[v].n / 2) enable = 1'b1;
        px.push_back(d);
        pix(d, i == 0, i == vecs[v].n - 1);
      end
      idle(20);
      check($sformatf("v%0d frame_done", v), 64'(done_cnt - d0), 64'(vecs[v].exp_done));
      check($sformatf("v%0d burst_valid", v), burst_valid, vecs[v].exp_burst);
      if (vecs[v].en) model_frame(px);
      drain($sformatf("v%0d word", v), cnt);
      check($sformatf("v%0d word_count", v), 64'(cnt), 64'(vecs[v].exp_words));
    end

    // Overflow: 300 pixels into a stalled 64-deep FIFO.
    do_reset();
    enable = 1'b1;
    px = {};
    for (int i = 0; i < 300; i++) begin
      if (i < 256) px.push_back(16'(i));
      pix(16'(i), i == 0, 1'b0);
    end
    check("ovf overflow", overflow, 1'b1);
    check("ovf drop_count", drop_count, 16'd11);
    check("ovf burst_valid", burst_valid, 1'b1);
    for (int i = 300; i < 304; i++) begin
      clear_status = (i == 303);
      pix(16'(i), 1'b0, 1'b0);
    end
    clear_status = 1'b0;
    check("clr+drop overflow", overflow, 1'b1);
    check("clr+drop drop_count", drop_count, 16'd1);
    clear_status = 1'b1; tick(); clear_status = 1'b0;
    check("clr overflow", overflow, 1'b0);
    check("clr drop_count", drop_count, 16'd0);
    exp_q = {};
    model_frame(px);
    drain("ovf word", cnt);
    check("ovf word_count", 64'(cnt), 64'd64);
    // Beat count must still be burst-aligned: one data word then 15 pads.
    d0 = done_cnt;
    pix(16'h0BEE, 1'b0, 1'b1);
    idle(20);
    check("ovf eof frame_done", 64'(done_cnt - d0), 64'd1);
    exp_q = {};
    exp_q.push_back(64'h0000_0000_0000_0BEE);
    repeat (15) exp_q.push_back(64'h0);
    drain("ovf tail word", cnt);
    check("ovf tail count", 64'(cnt), 64'd16);

    // Concurrent push and pop while full.
    do_reset();
    enable = 1'b1;
    px = {};
    for (int i = 0; i < 288; i++) begin
      if (i >= 32) px.push_back(16'(i));
      dout_ready = (i >= 256) && (i % 4 == 3);
      pix(16'(i), i == 0, 1'b0);
    end
    dout_ready = 1'b0;
    check("full overflow", overflow, 1'b0);
    check("full drop_count", drop_count, 16'd0);
    exp_q = {};
    model_frame(px);
    drain("full word", cnt);
    check("full word_count", 64'(cnt), 64'd64);

    // Reset in the middle of a frame.
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 30; i++) pix(16'(i + 7), i == 0, 1'b0);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) pix(16'hAAAA, 1'b0, 1'b0);
    px = {};
    d0 = done_cnt;
    for (int i = 0; i < 8; i++) begin
      px.push_back(16'(16'h100 + i));
      pix(16'(16'h100 + i), i == 0, i == 7);
    end
    idle(20);
    check("midrst frame_done", 64'(done_cnt - d0), 64'd1);
    exp_q = {};
    model_frame(px);
    drain("midrst word", cnt);
    check("midrst word_count", 64'(cnt), 64'd16);

    // Randomized frames with a random writer, checked by the scoreboard.
    do_reset();
    exp_q = {};
    exp_frames = 0;
    d0 = done_cnt;
    mon_en = 1'b1;
    rnd_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      en  = ($urandom_range(0, 3) != 0);
      len = $urandom_range(1, 70);
      px = {};
      for (int i = 0; i < len; i++) px.push_back(16'($urandom));
      if (en) begin
        model_frame(px);
        exp_frames++;
      end
      enable = en;
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 2) == 0) tick();
        pix(px[i], i == 0, i == len - 1);
        if (i == 0) enable = 1'($urandom_range(0, 1));
      end
      idle(24);
      repeat ($urandom_range(0, 5)) pix(16'($urandom), 1'b0, 1'b0);
    end
    rnd_ready = 1'b0;
    dout_ready = 1'b1;
    idle(100);
    mon_en = 1'b0;
    dout_ready = 1'b0;
    check("rnd leftover words", 64'(exp_q.size()), 64'd0);
    check("rnd frame_done count", 64'(done_cnt - d0), 64'(exp_frames));
    check("rnd overflow", overflow, 1'b0);
    check("rnd drop_count", drop_count, 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
